des_key_sched: RTL
==================

# des_key_sched

Sequential DES key schedule unit that sits directly upstream of the PC-2 compression stage (`p_box_56_48`). It accepts a 64-bit DES key and applies PC-1 to form the 56-bit C/D pair. It then steps through the 16 rounds, rotating C and D by the DES shift schedule and presenting one 56-bit post-rotation C/D value per round. Encrypt order uses left rotations (K1..K16); decrypt order uses right rotations (K16..K1). A valid/ready handshake paces delivery, so a single iterative Feistel datapath can consume one round key per accepted beat.

## Interface
- No parameters.
- `clk`  in  1  — rising-edge clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `key_i`  in  64  — DES key; `key_i[63]` = FIPS bit 1; parity bits ignored.
- `decrypt_i`  in  1  — sampled with `start_i`; 0 = encrypt order, 1 = decrypt order.
- `start_i`  in  1  — single-cycle load request; honoured only in IDLE.
- `rk_ready_i`  in  1  — downstream accepts current C/D.
- `rk_valid_o`  out  1  — `cd_o`/`round_o` valid.
- `cd_o`  out  56  — rotated C/D for current round; `cd_o[55:28]` = C, `[27:0]` = D; feeds PC-2.
- `round_o`  out  4  — DES round number minus 1 (0 = K1 … 15 = K16).
- `busy_o`  out  1  — high while in RUN.
- `done_o`  out  1  — one-cycle pulse after the final round is accepted.

## Operation
- PC-1 (output MSB first, FIPS bit numbers):
  - C: 57 49 41 33 25 17 9 1 58 50 42 34 26 18 10 2 59 51 43 35 27 19 11 3 60 52 44 36
  - D: 63 55 47 39 31 23 15 7 62 54 46 38 30 22 14 6 61 53 45 37 29 21 13 5 28 20 12 4
- Shift amount per round index r: 1 for r ∈ {0, 1, 8, 15}, otherwise 2. Total is 28, so CD16 = CD0.
- C and D are rotated independently as 28-bit fields; there is never any carry between C and D.
- FSM states:
  - IDLE:
    - `start_i` → load `cd_q`, go to RUN.
    - Encrypt load: `cd_q` ← rol1(PC1(key)), `rnd_q` ← 0.
    - Decrypt load: `cd_q` ← PC1(key), `rnd_q` ← 15.
  - RUN:
    - `rk_valid_o` = 1, `cd_o` = `cd_q`, `round_o` = `rnd_q`.
    - On handshake (valid & ready), not the last round:
      - Encrypt: `rnd_q`+1; `cd_q` rotated left by shift(`rnd_q`+1).
      - Decrypt: `rnd_q`−1; `cd_q` rotated right by shift(`rnd_q`).
    - On handshake of the last round (`rnd_q` = 15 for encrypt, 0 for decrypt): go to IDLE, `cd_q` ← 0 (key zeroization), `done_o` pulses next cycle.
- Without a handshake, every register and output holds.
- `start_i` is ignored in RUN; a running schedule is never aborted or restarted.
- `decrypt_i` and `key_i` are only sampled at start; later changes have no effect.

## Timing
- Reset values: state IDLE, `cd_o` = 0, `round_o` = 0, `rk_valid_o` = 0, `busy_o` = 0, `done_o` = 0.
- Reset asserted mid-schedule aborts immediately and produces no `done_o`.
- `start_i` at edge N → `rk_valid_o` = 1 and `busy_o` = 1 from edge N+1.
- First C/D is registered; there is no combinational path from `key_i` to `cd_o`.
- With `rk_ready_i` held high, 16 consecutive valid beats occur at N+1..N+16.
- `done_o` = 1 for edge N+17 only; `busy_o` = 0 from N+17.
- Earliest next accepted `start_i` is at edge N+17 (the `done_o` cycle); that start yields valid again at N+18.
- `rk_valid_o` never drops while a beat is pending (AXI-style hold rule).
- `done_o` and `rk_valid_o` are never high in the same cycle.

## Test plan
- **Encrypt order:** key 0x133457799BBCDFF1, `decrypt_i` = 0, ready high.
  - Beat 0: `cd_o` = 0xE19955FAACCF1E, `round_o` = 0; PC-2 of it = 0x1B02EFFC7072.
  - Beat 1: `cd_o` = 0xC332ABF5599E3D.
  - Beat 15: `cd_o` = 0xF0CCAAF556678F.
  - `done_o` pulses one cycle after beat 15.
- **Decrypt order:** same key, `decrypt_i` = 1.
  - Beat 0: `cd_o` = 0xF0CCAAF556678F, `round_o` = 15.
  - Beats k (k = 0..15) equal the encrypt beats 15−k in reverse order.
  - Last beat: `round_o` = 0, `cd_o` = 0xE19955FAACCF1E.
- **Backpressure:** random `rk_ready_i` (about 50%).
  - Sequence is identical to the reference model; `cd_o`/`round_o` are stable while valid & !ready.
  - `done_o` follows exactly 16 handshakes.
- **Start while busy:** `start_i` pulsed with a different key at beats 3 and 10.
  - Sequence is unaffected; no extra beats are produced.
- **Reset mid-run:** `rst` asserted after beat 7.
  - All outputs are 0 immediately with no `done_o`.
  - A new start after release gives correct beat 0.
- **Zeroization and back-to-back:** `start_i` in the `done_o` cycle.
  - `cd_q` = 0 during that cycle (internal probe).
  - Second schedule begins the following cycle with correct values.

Source files
------------

// File: rtl/des_key_sched.sv
// ============================================================================
// Module   : des_key_sched
// Purpose  : Iterative DES key schedule that emits one post-rotation C/D pair
//            per round (encrypt K1..K16 or decrypt K16..K1) over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        start_i,
    input  logic        rk_ready_i,
    output logic        rk_valid_o,
    output logic [55:0] cd_o,
    output logic [3:0]  round_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // PC-1 selection, output MSB first, FIPS bit numbering (bit 1 = key_i[63])
    localparam int c_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    state_t      r_state, w_state_nxt;
    logic [55:0] r_cd,    w_cd_nxt;
    logic [3:0]  r_rnd,   w_rnd_nxt;
    logic        r_dec,   w_dec_nxt;
    logic        r_done,  w_done_nxt;
    logic [55:0] w_pc1;
    logic        w_last;
    logic        w_unused_parity;

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] res;
        res = '0;
        for (int i = 0; i < 56; i++) begin
            res[55-i] = key[64-c_PC1[i]];
        end
        return res;
    endfunction

    // Rounds 0, 1, 8 and 15 shift by one; all others by two
    function automatic logic shift_two(input logic [3:0] r);
        return !((r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15));
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign w_pc1  = pc1(key_i);
    assign w_last = r_dec ? (r_rnd == 4'd0) : (r_rnd == 4'd15);

    // Parity bits of the key are intentionally dropped by PC-1
    assign w_unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                               key_i[24], key_i[16], key_i[8],  key_i[0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_cd;
        w_rnd_nxt   = r_rnd;
        w_dec_nxt   = r_dec;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_RUN;
                    w_dec_nxt   = decrypt_i;
                    if (decrypt_i) begin
                        w_cd_nxt  = w_pc1;
                        w_rnd_nxt = 4'd15;
                    end else begin
                        w_cd_nxt  = {rol28(w_pc1[55:28], 1'b0), rol28(w_pc1[27:0], 1'b0)};
                        w_rnd_nxt = 4'd0;
                    end
                end
            end
            S_RUN: begin
                if (rk_ready_i) begin
                    if (w_last) begin
                        // Final beat accepted: wipe key material and return
                        w_state_nxt = S_IDLE;
                        w_cd_nxt    = '0;
                        w_rnd_nxt   = 4'd0;
                        w_done_nxt  = 1'b1;
                    end else if (r_dec) begin
                        w_rnd_nxt = r_rnd - 4'd1;
                        w_cd_nxt  = {ror28(r_cd[55:28], shift_two(r_rnd)),
                                     ror28(r_cd[27:0],  shift_two(r_rnd))};
                    end else begin
                        w_rnd_nxt = r_rnd + 4'd1;
                        w_cd_nxt  = {rol28(r_cd[55:28], shift_two(r_rnd + 4'd1)),
                                     rol28(r_cd[27:0],  shift_two(r_rnd + 4'd1))};
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cd    <= '0;
            r_rnd   <= 4'd0;
            r_dec   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cd    <= w_cd_nxt;
            r_rnd   <= w_rnd_nxt;
            r_dec   <= w_dec_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign rk_valid_o = (r_state == S_RUN);
    assign busy_o     = (r_state == S_RUN);
    assign cd_o       = r_cd;
    assign round_o    = r_rnd;
    assign done_o     = r_done;

endmodule

`default_nettype wire
